imm_controller: RTL and testbench

//   Decode-stage immediate formatter for the RV32I core.
//   - Takes the raw instruction immediate fields (immA..immD) and the opcode; emits one 20-bit immediate.
//   - Fields are assembled per instruction format (U/J/I/B/S).
//   - The immediate is available combinationally, plus a registered copy and format tag for the next stage.

---
 rtl/imm_controller.sv | 132 +++++++++++++
 tb/tb_imm_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_controller.sv
// imm_controller: decode-stage immediate formatter for the RV32I core.
// Assembles a 20-bit immediate from the raw instruction fields according to
// the instruction format selected by the opcode (U/J/I/B/S). The immediate is
// available combinationally and is also registered, together with a format
// tag, for the next pipeline stage.
//
// Build option:
//   IMM_SIGN_EXT_EN - when defined, the I, B and S forms fill imm[19:12] with
//                     copies of the field MSB instead of zeros. U and J forms
//                     are unaffected. Default (undefined) is zero fill.
//
// The implicit zero LSB of J and B offsets is not produced here; the consumer
// appends it. funct3/funct7 are carried for interface completeness only and
// never influence the result (shift-immediates pass the full immB field).

module imm_controller (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [19:0] immA,
  input  logic [11:0] immB,
  input  logic [6:0]  immC,
  input  logic [4:0]  immD,
  output logic [19:0] imm,
  output logic [19:0] ImmQ,
  output logic [2:0]  ImmKindQ
);

  // RV32I major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  // Format tag carried alongside the registered immediate.
  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_U    = 3'd1,
    KIND_J    = 3'd2,
    KIND_I    = 3'd3,
    KIND_B    = 3'd4,
    KIND_S    = 3'd5
  } imm_kind_t;

  imm_kind_t   kind;
  logic [7:0]  fill_i;
  logic [7:0]  fill_bs;
  logic [19:0] imm_u;
  logic [19:0] imm_j;
  logic [19:0] imm_i;
  logic [19:0] imm_b;
  logic [19:0] imm_s;

  // Reserved decode inputs are reduced into a sink so they remain visibly
  // unused without affecting any result.
  logic unused_reserved;
  assign unused_reserved = ^{funct3, funct7};

`ifdef IMM_SIGN_EXT_EN
  // Upper bits replicate the field MSB: immB[11] for I, immC[6] for B and S.
  assign fill_i  = {8{immB[11]}};
  assign fill_bs = {8{immC[6]}};
`else
  // Upper bits are zero for I, B and S forms.
  assign fill_i  = 8'h00;
  assign fill_bs = 8'h00;
`endif

  // Per-format field assembly; the opcode decode below only selects.
  assign imm_u = immA;
  assign imm_j = {immA[19], immA[7:0], immA[8], immA[18:9]};
  assign imm_i = {fill_i, immB};
  assign imm_b = {fill_bs, immC[6], immD[0], immC[5:0], immD[4:1]};
  assign imm_s = {fill_bs, immC, immD};

  // Opcode decode: select the formatted immediate and its format tag.
  // Unrecognised or unknown opcodes fall to the default of zero / no format.
  always_comb begin
    imm  = 20'h00000;
    kind = KIND_NONE;
    case (Opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm  = imm_u;
        kind = KIND_U;
      end
      OPC_JAL: begin
        imm  = imm_j;
        kind = KIND_J;
      end
      OPC_JALR, OPC_LOAD, OPC_ARI_ITYPE: begin
        imm  = imm_i;
        kind = KIND_I;
      end
      OPC_BRANCH: begin
        imm  = imm_b;
        kind = KIND_B;
      end
      OPC_STORE: begin
        imm  = imm_s;
        kind = KIND_S;
      end
      OPC_ARI_RTYPE: begin
        imm  = 20'h00000;
        kind = KIND_NONE;
      end
      default: begin
        imm  = 20'h00000;
        kind = KIND_NONE;
      end
    endcase
  end

  // Next-stage copy: capture immediate and tag every rising edge; an
  // asserted reset clears both at once and discards any in-flight value.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ImmQ     <= 20'h00000;
      ImmKindQ <= 3'd0;
    end else begin
      ImmQ     <= imm;
      ImmKindQ <= kind;
    end
  end

endmodule

// File: tb/tb_imm_controller.sv
// tb_imm_controller: directed checks of imm_controller's combinational
// formatting, registered copy/tag, and asynchronous reset behaviour.

module tb_imm_controller;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

`ifdef IMM_SIGN_EXT_EN
  localparam logic [19:0] EXP_B     = 20'hFFD55;
  localparam logic [19:0] EXP_S     = 20'hFFAAB;
  localparam logic [19:0] EXP_I_NEG = 20'hFF800;
`else
  localparam logic [19:0] EXP_B     = 20'h00D55;
  localparam logic [19:0] EXP_S     = 20'h00AAB;
  localparam logic [19:0] EXP_I_NEG = 20'h00800;
`endif

  logic        Clock;
  logic        Reset_n;
  logic [6:0]  Opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [19:0] immA;
  logic [11:0] immB;
  logic [6:0]  immC;
  logic [4:0]  immD;
  logic [19:0] imm;
  logic [19:0] ImmQ;
  logic [2:0]  ImmKindQ;

  int checks = 0;
  int errors = 0;

  imm_controller dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Opcode   (Opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .immA     (immA),
    .immB     (immB),
    .immC     (immC),
    .immD     (immD),
    .imm      (imm),
    .ImmQ     (ImmQ),
    .ImmKindQ (ImmKindQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a new instruction on the falling edge, then let the decode settle.
  task automatic applyStimulus(input logic [6:0] op, input logic [19:0] a, input logic [11:0] b,
                               input logic [6:0] c, input logic [4:0] d,
                               input logic [2:0] f3, input logic [6:0] f7);
    @(negedge Clock);
    Opcode = op;
    immA   = a;
    immB   = b;
    immC   = c;
    immD   = d;
    funct3 = f3;
    funct7 = f7;
    #1;
  endtask

  // Check the combinational immediate now, then the registered copy/tag
  // just after the following rising edge.
  task automatic checkOutput(input string tag, input logic [19:0] exp_imm, input logic [2:0] exp_kind);
    check20({tag, ".imm"}, imm, exp_imm);
    @(posedge Clock);
    #1;
    check20({tag, ".ImmQ"}, ImmQ, exp_imm);
    check3({tag, ".ImmKindQ"}, ImmKindQ, exp_kind);
  endtask

  initial begin
    Reset_n = 1'b0;
    Opcode  = OPC_LUI;
    immA    = 20'hABCDE;
    immB    = 12'h000;
    immC    = 7'h00;
    immD    = 5'h00;
    funct3  = 3'd0;
    funct7  = 7'd0;
    #2;
    check20("reset.ImmQ", ImmQ, 20'h00000);
    check3("reset.ImmKindQ", ImmKindQ, 3'd0);
    check20("reset.imm_tracks", imm, 20'hABCDE);
    @(posedge Clock);
    #1;
    check20("reset_held.ImmQ", ImmQ, 20'h00000);

    @(negedge Clock);
    Reset_n = 1'b1;

    // U forms
    applyStimulus(OPC_LUI,   20'hABCDE, 12'h123, 7'h11, 5'h02, 3'd0, 7'd0);
    checkOutput("lui", 20'hABCDE, 3'd1);
    applyStimulus(OPC_AUIPC, 20'hABCDE, 12'h123, 7'h11, 5'h02, 3'd5, 7'h20);
    checkOutput("auipc", 20'hABCDE, 3'd1);

    // J form
    applyStimulus(OPC_JAL, 20'hABCDE, 12'h000, 7'h00, 5'h00, 3'd0, 7'd0);
    checkOutput("jal", 20'hEF15E, 3'd2);

    // B and S forms with the same fields
    applyStimulus(OPC_BRANCH, 20'h00000, 12'h000, 7'h55, 5'h0B, 3'd1, 7'd0);
    checkOutput("branch", EXP_B, 3'd4);
    applyStimulus(OPC_STORE, 20'h00000, 12'h000, 7'h55, 5'h0B, 3'd2, 7'd0);
    checkOutput("store", EXP_S, 3'd5);

    // I forms at the sign boundary
    applyStimulus(OPC_JALR, 20'h00000, 12'h800, 7'h00, 5'h00, 3'd0, 7'd0);
    checkOutput("jalr", EXP_I_NEG, 3'd3);
    applyStimulus(OPC_LOAD, 20'h00000, 12'h800, 7'h00, 5'h00, 3'd2, 7'd0);
    checkOutput("load", EXP_I_NEG, 3'd3);
    applyStimulus(OPC_ARI_ITYPE, 20'h00000, 12'h800, 7'h00, 5'h00, 3'd0, 7'd0);
    checkOutput("itype", EXP_I_NEG, 3'd3);
    applyStimulus(OPC_ARI_ITYPE, 20'h00000, 12'h7FF, 7'h00, 5'h00, 3'd0, 7'd0);
    checkOutput("itype_pos", 20'h007FF, 3'd3);

    // Shift-immediate: funct3/funct7 must not alter the full immB pass-through
    applyStimulus(OPC_ARI_ITYPE, 20'h00000, 12'h41F, 7'h00, 5'h00, 3'd5, 7'h20);
    checkOutput("itype_shift", 20'h0041F, 3'd3);

    // R-type with random fields
    applyStimulus(OPC_ARI_RTYPE, 20'($urandom), 12'($urandom), 7'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom));
    checkOutput("rtype", 20'h00000, 3'd0);

    // Unknown opcode
    applyStimulus(7'bxxxxxxx, 20'hFFFFF, 12'hFFF, 7'h7F, 5'h1F, 3'd0, 7'd0);
    checkOutput("opcode_x", 20'h00000, 3'd0);

    // Inputs changing between edges move imm only
    applyStimulus(OPC_LUI, 20'h12345, 12'h000, 7'h00, 5'h00, 3'd0, 7'd0);
    checkOutput("hold_setup", 20'h12345, 3'd1);
    #2;
    Opcode = OPC_JAL;
    immA   = 20'hABCDE;
    #1;
    check20("hold.imm", imm, 20'hEF15E);
    check20("hold.ImmQ", ImmQ, 20'h12345);
    check3("hold.ImmKindQ", ImmKindQ, 3'd1);

    // Mid-stream reset between edges, then recapture after release
    @(posedge Clock);
    #1;
    check20("pre_reset.ImmQ", ImmQ, 20'hEF15E);
    #2;
    Reset_n = 1'b0;
    #1;
    check20("async_reset.ImmQ", ImmQ, 20'h00000);
    check3("async_reset.ImmKindQ", ImmKindQ, 3'd0);
    Opcode = OPC_STORE;
    immC   = 7'h55;
    immD   = 5'h0B;
    #1;
    check20("reset_imm_tracks", imm, EXP_S);
    @(posedge Clock);
    #1;
    check20("reset_held2.ImmQ", ImmQ, 20'h00000);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    check20("post_reset.ImmQ", ImmQ, EXP_S);
    check3("post_reset.ImmKindQ", ImmKindQ, 3'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
